// File: rtl/seg7_pkg.sv
// Shared constants for the segment read-back path: hex glyph patterns,
// segment bit positions and the frame capture state type.
package seg7_pkg;

    localparam int SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seg7_scan_capture_encoder.sv
// Segment-to-hex encoder: inverse of the hex glyph table. Anything that is
// not one of the 16 glyphs (blank included) is reported as invalid.
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed 7-segment scan bus, debounces each scan step and
// publishes complete multi-digit hex frames over a valid/ready handshake.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [7:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);
    localparam int         SW     = 8 + DIGITS;

    logic [SW-1:0]     prev_reg, prev_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              commit, same;
    logic [3:0]        enc_nibble;
    logic              enc_valid;
    logic [DIGITS-1:0] commit_mask;

    logic [3:0]        work_hex_reg [DIGITS];
    logic [DIGITS-1:0] work_dp_reg, work_err_reg, seen_reg, seen_next;
    logic [3:0]        pub_hex_reg  [DIGITS];
    logic [DIGITS-1:0] pub_dp_reg, pub_err_reg;
    logic              overrun_reg;

    cap_state_t        state_reg, state_next;
    logic              full, publish, drop_frame, set_overrun, clr_overrun;

    seg7_encoder u_encoder (
        .seg    (seg_in[6:0]),
        .nibble (enc_nibble),
        .valid  (enc_valid)
    );

    assign same = ({seg_in, dig_sel} == prev_reg);

    // Commit fires only on the transition into STABLE, so a held pattern commits once.
    always_comb begin
        cnt_next  = cnt_reg;
        prev_next = prev_reg;
        commit    = 1'b0;
        if (sample_en) begin
            if (!$onehot(dig_sel)) begin
                cnt_next = '0;
            end else if (same) begin
                if (cnt_reg != STABLE) begin
                    cnt_next = cnt_reg + 4'd1;
                    commit   = (cnt_reg == STABLE - 4'd1);
                end
            end else begin
                cnt_next  = 4'd1;
                prev_next = {seg_in, dig_sel};
                commit    = (STABLE == 4'd1);
            end
        end
    end

    assign commit_mask = commit ? dig_sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            prev_reg <= '0;
        end else begin
            cnt_reg  <= cnt_next;
            prev_reg <= prev_next;
        end
    end

    // A commit landing on the publish/drop edge belongs to the next frame.
    assign full      = &seen_reg;
    assign seen_next = ((publish || drop_frame) ? '0 : seen_reg) | commit_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) work_hex_reg[i] <= '0;
            work_dp_reg  <= '0;
            work_err_reg <= '0;
            seen_reg     <= '0;
        end else begin
            seen_reg <= seen_next;
            for (int i = 0; i < DIGITS; i++) begin
                if (commit_mask[i]) begin
                    work_dp_reg[i]  <= seg_in[SEG_DP_BIT];
                    work_err_reg[i] <= ~enc_valid;
                    if (enc_valid) work_hex_reg[i] <= enc_nibble;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= COLLECT;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (full) state_next = OFFER;
            OFFER:   if (frame_ready && !full) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_comb begin
        publish     = 1'b0;
        drop_frame  = 1'b0;
        set_overrun = 1'b0;
        clr_overrun = 1'b0;
        frame_valid = (state_reg == OFFER);
        case (state_reg)
            COLLECT: publish = full;
            OFFER: begin
                publish     = full && frame_ready;
                drop_frame  = full && !frame_ready;
                set_overrun = drop_frame;
                clr_overrun = frame_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) pub_hex_reg[i] <= '0;
            pub_dp_reg  <= '0;
            pub_err_reg <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (publish) begin
                pub_hex_reg <= work_hex_reg;
                pub_dp_reg  <= work_dp_reg;
                pub_err_reg <= work_err_reg;
            end
            if (set_overrun)      overrun_reg <= 1'b1;
            else if (clr_overrun) overrun_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
        assign hex_out[4*gi +: 4] = pub_hex_reg[gi];
    end

    assign dp_out    = pub_dp_reg;
    assign digit_err = pub_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scenarios plus randomized scanning,
// checked every cycle against a frame-level behavioural model.
module tb_seg7_scan_capture;

    localparam int D = 4;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sample_en = 1'b0;
    logic [7:0]     seg_in = 8'h00;
    logic [D-1:0]   dig_sel = '0;
    logic           frame_ready = 1'b0;
    logic [4*D-1:0] hex_out;
    logic [D-1:0]   dp_out, digit_err;
    logic           frame_valid, overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_capture #(.DIGITS(D), .STABLE_CNT(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Behavioural model: run length of the current scan step, a working frame
    // per digit and the published frame.
    int             m_run = 0;
    logic [7:0]     m_pseg = 8'h00;
    logic [D-1:0]   m_psel = '0;
    logic [3:0]     m_wnib [D];
    logic           m_wdp [D];
    logic           m_werr [D];
    logic           m_seen [D];
    logic [4*D-1:0] m_hex = '0;
    logic [D-1:0]   m_dp = '0, m_err = '0;
    logic           m_valid = 1'b0, m_ovr = 1'b0;
    logic           m_full, m_commit, m_found;
    int             m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_pseg = 8'h00; m_psel = '0;
            for (int i = 0; i < D; i++) begin
                m_wnib[i] = 4'h0; m_wdp[i] = 1'b0; m_werr[i] = 1'b0; m_seen[i] = 1'b0;
            end
            m_hex = '0; m_dp = '0; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            m_full = 1'b1;
            for (int i = 0; i < D; i++) m_full = m_full & m_seen[i];
            if (m_full) begin
                if (m_valid && !frame_ready) begin
                    m_ovr = 1'b1;
                end else begin
                    for (int i = 0; i < D; i++) begin
                        m_hex[4*i +: 4] = m_wnib[i]; m_dp[i] = m_wdp[i]; m_err[i] = m_werr[i];
                    end
                    if (m_valid) m_ovr = 1'b0;
                    m_valid = 1'b1;
                end
                for (int i = 0; i < D; i++) m_seen[i] = 1'b0;
            end else if (m_valid && frame_ready) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            m_commit = 1'b0;
            if (sample_en) begin
                if ($countones(dig_sel) != 1) begin
                    m_run = 0;
                end else if (seg_in == m_pseg && dig_sel == m_psel) begin
                    if (m_run < S) begin
                        m_run++;
                        m_commit = (m_run == S);
                    end
                end else begin
                    m_pseg = seg_in; m_psel = dig_sel; m_run = 1;
                    m_commit = (S == 1);
                end
            end
            if (m_commit) begin
                m_idx = 0;
                for (int i = 0; i < D; i++) if (dig_sel[i]) m_idx = i;
                m_found = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (tbl[k] == seg_in[6:0]) begin
                        m_found = 1'b1;
                        m_wnib[m_idx] = 4'(k);
                    end
                end
                m_werr[m_idx] = !m_found;
                m_wdp[m_idx]  = seg_in[7];
                m_seen[m_idx] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        n_vec++;
        if (hex_out !== m_hex || dp_out !== m_dp || digit_err !== m_err ||
            frame_valid !== m_valid || overrun !== m_ovr) begin
            n_err++;
            $display("FAIL model t=%0t: got hex=%h dp=%b err=%b v=%b ovr=%b, want hex=%h dp=%b err=%b v=%b ovr=%b",
                     $time, hex_out, dp_out, digit_err, frame_valid, overrun,
                     m_hex, m_dp, m_err, m_valid, m_ovr);
        end
        if (rst_n && frame_valid && frame_ready)
            $display("handshake t=%0t hex=%h dp=%b err=%b ovr=%b", $time, hex_out, dp_out, digit_err, overrun);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic [7:0] seg, input logic [D-1:0] sel, input logic rdy);
        @(posedge clk);
        #1;
        sample_en = en; seg_in = seg; dig_sel = sel; frame_ready = rdy;
    endtask

    task automatic scan(input logic [7:0] seg, input logic [D-1:0] sel, input int n);
        for (int i = 0; i < n; i++) step(1'b1, seg, sel, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, '0, 1'b0);
    endtask

    task automatic frame4(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
        scan(s0, 4'b0001, S); scan(s1, 4'b0010, S); scan(s2, 4'b0100, S); scan(s3, 4'b1000, S);
    endtask

    task automatic handshake();
        step(1'b0, 8'h00, '0, 1'b1);
        step(1'b0, 8'h00, '0, 1'b0);
        @(negedge clk);
        check("hs_valid_drop", 32'(frame_valid), 32'd0);
        check("hs_overrun_clr", 32'(overrun), 32'd0);
    endtask

    initial begin
        logic [7:0]   r_seg;
        logic [D-1:0] r_sel;
        int           r_hold;

        idle(3);
        @(negedge clk);
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        step(1'b0, 8'h00, '0, 1'b0);
        rst_n = 1'b1;

        // Basic frame and its latency
        frame4(8'h06, 8'h5B, 8'h4F, 8'h66);
        idle(1);
        @(negedge clk);
        check("basic_valid_early", 32'(frame_valid), 32'd0);
        idle(1);
        @(negedge clk);
        check("basic_valid", 32'(frame_valid), 32'd1);
        check("basic_hex", 32'(hex_out), 32'h4321);
        check("basic_err", 32'(digit_err), 32'h0);
        check("basic_dp", 32'(dp_out), 32'h0);
        handshake();

        // Debounce: glitches and a 2-strobe run never commit
        scan(8'h06, 4'b0001, 1); scan(8'h07, 4'b0001, 1); scan(8'h06, 4'b0001, 1);
        scan(8'h06, 4'b0001, 3); scan(8'h07, 4'b0001, 2);
        scan(8'h7D, 4'b0010, 3); scan(8'h39, 4'b0100, 3); scan(8'h71, 4'b1000, 3);
        idle(2);
        @(negedge clk);
        check("debounce_valid", 32'(frame_valid), 32'd1);
        check("debounce_hex", 32'(hex_out), 32'hFC61);
        handshake();

        // Invalid blank pattern keeps old nibble; dp captured
        frame4(8'h3F, 8'hFF, 8'h00, 8'h79);
        idle(2);
        @(negedge clk);
        check("inv_hex", 32'(hex_out), 32'hEC80);
        check("inv_err", 32'(digit_err), 32'h4);
        check("inv_dp", 32'(dp_out), 32'h2);
        handshake();

        // Select errors break the run
        scan(8'h06, 4'b0001, 2); step(1'b1, 8'h06, 4'b0000, 1'b0);
        scan(8'h06, 4'b0001, 2); step(1'b1, 8'h06, 4'b0011, 1'b0);
        scan(8'h5B, 4'b0010, 3); scan(8'h4F, 4'b0100, 3); scan(8'h66, 4'b1000, 3);
        idle(2);
        @(negedge clk);
        check("selerr_nocommit", 32'(frame_valid), 32'd0);
        scan(8'h06, 4'b0001, 3);
        idle(2);
        @(negedge clk);
        check("selerr_valid", 32'(frame_valid), 32'd1);
        check("selerr_hex", 32'(hex_out), 32'h4321);

        // Overrun: second frame dropped while the first is held
        frame4(8'h7F, 8'h6F, 8'h77, 8'h7C);
        idle(2);
        @(negedge clk);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_hold_hex", 32'(hex_out), 32'h4321);
        check("ovr_hold_valid", 32'(frame_valid), 32'd1);
        handshake();

        // Ready coinciding with completion loads the new frame
        frame4(8'h7F, 8'h6F, 8'h77, 8'h7C);
        idle(2);
        @(negedge clk);
        check("coin_first_hex", 32'(hex_out), 32'hBA98);
        frame4(8'h39, 8'h5E, 8'h79, 8'h71);
        step(1'b0, 8'h00, '0, 1'b1);
        step(1'b0, 8'h00, '0, 1'b0);
        @(negedge clk);
        check("coin_valid", 32'(frame_valid), 32'd1);
        check("coin_hex", 32'(hex_out), 32'hFEDC);
        check("coin_ovr", 32'(overrun), 32'd0);
        handshake();

        // Randomized scanning
        r_hold = 0; r_seg = 8'h00; r_sel = '0;
        for (int c = 0; c < 3000; c++) begin
            if (r_hold == 0) begin
                r_sel  = D'(1) << $urandom_range(0, D-1);
                if ($urandom_range(0, 9) == 0) r_sel = D'($urandom);
                r_seg  = {($urandom_range(0, 3) == 0), tbl[$urandom_range(0, 15)]};
                if ($urandom_range(0, 7) == 0) r_seg = 8'($urandom);
                r_hold = $urandom_range(1, 5);
            end
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, r_seg, r_sel, ($urandom_range(0, 5) == 0));
                r_hold--;
            end else begin
                step(1'b0, 8'($urandom), D'($urandom), ($urandom_range(0, 5) == 0));
            end
        end
        idle(2);
        step(1'b0, 8'h00, '0, 1'b1);
        idle(2);

        // Asynchronous reset mid-frame
        frame4(8'h06, 8'h5B, 8'h4F, 8'h66);
        idle(2);
        scan(8'h6D, 4'b0001, 3); scan(8'h7D, 4'b0010, 3);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hex", 32'(hex_out), 32'h0);
        check("arst_valid", 32'(frame_valid), 32'd0);
        idle(2);
        rst_n = 1'b1;
        scan(8'h7F, 4'b0001, 3); scan(8'h6F, 4'b0010, 3); scan(8'h77, 4'b0100, 3);
        idle(3);
        @(negedge clk);
        check("arst_partial", 32'(frame_valid), 32'd0);
        scan(8'h7C, 4'b1000, 3);
        idle(2);
        @(negedge clk);
        check("arst_new_valid", 32'(frame_valid), 32'd1);
        check("arst_new_hex", 32'(hex_out), 32'hBA98);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
